bcd_code_converter_seq: RTL and testbench
=========================================

// Module: bcd_code_converter_seq
// PURPOSE
//  Multi-digit BCD code converter. Converts a packed word of DIGITS BCD digits into a run-time
//  selected 4-bit decimal code, one digit per clock, LSD first. Valid/ready on both sides, so it
//  sits between lab stimulus/display stages as the sequential successor of the 1-digit converter.
//  Digits above 9 are flagged per digit, not silently mapped.
// PARAMETERS
//  DIGITS  4  number of BCD digits per word (>=1); data width = 4*DIGITS
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous, active-low reset
//  in_valid   in   1         in_data/in_mode valid
//  in_ready   out  1         converter can accept a word
//  in_data    in   4*DIGITS  packed BCD, digit k = in_data[4k+3:4k]
//  in_mode    in   2         0=BCD pass, 1=Excess-3, 2=9's complement, 3=Aiken 2421
//  out_valid  out  1         out_data/out_err valid
//  out_ready  in   1         downstream accepts result
//  out_data   out  4*DIGITS  converted digits, same packing
//  out_err    out  DIGITS    bit k set: input digit k was >9
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, out_data=0, out_err=0,
//    digit counter=0. Release mid-word discards the word; no partial result ever emitted.
//  - FSM IDLE -> CONV on in_valid&&in_ready: in_data, in_mode latched; counter=0.
//  - CONV: each edge converts digit[counter] into out_data/out_err slot counter; counter++.
//    After digit DIGITS-1 -> DONE. in_ready=0 throughout CONV.
//  - DONE: out_valid=1; out_data/out_err stable until out_valid&&out_ready.
//  - Latency: out_valid rises DIGITS cycles after the accepting edge (DIGITS=4 -> 4 cycles).
//  - in_ready = (state==IDLE) || (state==DONE && out_ready): simultaneous output handshake
//    and new input acceptance in DONE goes straight to CONV (zero bubble).
//  - DONE && out_ready && !in_valid -> IDLE; out_valid drops next cycle.
//  - Mode changes on in_mode while busy are ignored; the latched mode applies to whole word.
//  - Digit maps (d = 0..9): pass: d; Excess-3: d+3 (4-bit); 9's comp: 9-d;
//    2421: d<5 ? d : d+6 (5->1011 ... 9->1111).
//  - d in 10..15 in any mode: out digit=4'hF, out_err[k]=1. Other digits unaffected.
//  - out_err is per-word: cleared with all slots at acceptance, not sticky across words.
//  - No combinational path from in_* to out_*; out_ready only affects in_ready and FSM.
// STRUCTURE
//  - Package bcd_conv_pkg: mode typedef (MODE_BCD, MODE_XS3, MODE_NINES, MODE_2421),
//    FSM state typedef (IDLE, CONV, DONE), constant BCD_INVALID=4'hF.
//  - Sub-module bcd_digit_conv: combinational 4-bit digit + mode -> 4-bit code + err flag;
//    one instance, muxed by the digit counter. FSM, counter and result regs in top.
// TESTING (DIGITS=4)
//  - Reset: hold rst_n=0 mid-stream -> in_ready=1, out_valid=0, out_data=0, out_err=0.
//  - Excess-3: in_data=16'h1293, mode=1 -> after 4 cycles out_data=16'h45C6, out_err=4'b0000.
//  - 9's comp: 16'h1293, mode=2 -> 16'h8706; 2421: 16'h5678, mode=3 -> 16'hBCDE;
//    pass: 16'h9081, mode=0 -> 16'h9081.
//  - Invalid digit: 16'h12A3, mode=1 -> out_data=16'h45F6, out_err=4'b0010.
//  - Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; then
//    out_ready=1 with in_valid=1 -> same-cycle accept, next out_valid after 4 cycles.
//  - Reset mid-CONV (after 2 digits) -> no out_valid; next word converts correctly.

Source files
------------

// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the sequential BCD code converter.
// Mode encodings match the in_mode port values.
package bcd_conv_pkg;

    typedef enum logic [1:0] {
        MODE_BCD   = 2'd0,
        MODE_XS3   = 2'd1,
        MODE_NINES = 2'd2,
        MODE_2421  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] BCD_INVALID = 4'hF;

endpackage

// File: rtl/bcd_digit_conv.sv
// Combinational single-digit converter: one BCD digit plus mode in, one 4-bit code plus error out.
// Non-decimal digits are reported rather than mapped.
module bcd_digit_conv
    import bcd_conv_pkg::*;
(
    input  logic [3:0] digit_i,
    input  mode_e      mode_i,
    output logic [3:0] code_o,
    output logic       err_o
);

    always_comb begin
        code_o = digit_i;
        err_o  = 1'b0;
        if (digit_i > 4'd9) begin
            code_o = BCD_INVALID;
            err_o  = 1'b1;
        end else begin
            case (mode_i)
                MODE_BCD:   code_o = digit_i;
                MODE_XS3:   code_o = digit_i + 4'd3;
                MODE_NINES: code_o = 4'd9 - digit_i;
                // 2421 keeps 0..4 and jumps 5..9 up to 1011..1111
                MODE_2421:  code_o = (digit_i < 4'd5) ? digit_i : digit_i + 4'd6;
                default:    code_o = digit_i;
            endcase
        end
    end

endmodule

// File: rtl/bcd_code_converter_seq.sv
// Multi-digit BCD code converter: latches a packed word and mode, converts one digit per clock
// LSD first through a single shared digit converter, then holds the result until taken.
module bcd_code_converter_seq
    import bcd_conv_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic [1:0]            in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic [DIGITS-1:0]     out_err
);

    localparam int             CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIGITS - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   data_q, data_d;
    mode_e                 mode_q, mode_d;
    logic [4*DIGITS-1:0]   out_data_q, out_data_d;
    logic [DIGITS-1:0]     out_err_q, out_err_d;

    logic [3:0]            digit_arr [DIGITS];
    logic [3:0]            cur_digit;
    logic [3:0]            code;
    logic                  code_err;
    logic                  accept;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_unpack
        assign digit_arr[gi] = data_q[4*gi +: 4];
    end

    assign cur_digit = digit_arr[cnt_q];

    bcd_digit_conv u_conv (
        .digit_i (cur_digit),
        .mode_i  (mode_q),
        .code_o  (code),
        .err_o   (code_err)
    );

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        mode_d     = mode_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;

        case (state_q)
            IDLE: ;
            CONV: begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (cnt_q == CW'(k)) begin
                        out_data_d[4*k +: 4] = code;
                        out_err_d[k]         = code_err;
                    end
                end
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Acceptance overrides the above so DONE can hand off and reload in one edge
        if (accept) begin
            state_d    = CONV;
            cnt_d      = '0;
            data_d     = in_data;
            mode_d     = mode_e'(in_mode);
            out_data_d = '0;
            out_err_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            mode_q     <= MODE_BCD;
            out_data_q <= '0;
            out_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            mode_q     <= mode_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

endmodule

// File: tb/tb_bcd_code_converter_seq.sv
// Scoreboard bench for the sequential BCD converter (DIGITS=4): expected words are queued on
// input handshake and compared on output handshake.
module tb_bcd_code_converter_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [3:0]  out_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic prev_valid = 1'b0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  err;
        int          acc;
    } exp_t;

    exp_t sb_q[$];

    bcd_code_converter_seq #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference code tables, indexed by decimal digit value
    function automatic exp_t model(input logic [15:0] d, input logic [1:0] m);
        logic [3:0] t_xs3  [10] = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
        logic [3:0] t_nine [10] = '{4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};
        logic [3:0] t_2421 [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        exp_t r;
        logic [3:0] dg;
        r.data = '0;
        r.err  = '0;
        r.acc  = 0;
        for (int k = 0; k < 4; k++) begin
            dg = d[4*k +: 4];
            if (dg >= 4'd10) begin
                r.data[4*k +: 4] = 4'hF;
                r.err[k]         = 1'b1;
            end else begin
                case (m)
                    2'd0: r.data[4*k +: 4] = dg;
                    2'd1: r.data[4*k +: 4] = t_xs3[dg];
                    2'd2: r.data[4*k +: 4] = t_nine[dg];
                    default: r.data[4*k +: 4] = t_2421[dg];
                endcase
            end
        end
        return r;
    endfunction

    // Output monitor: latency on rising out_valid, data/err on handshake
    always @(negedge clk) begin
        exp_t it;
        if (rst_n) begin
            if (out_valid && !prev_valid) begin
                if (sb_q.size() == 0) check("valid_without_word", 32'(out_valid), 32'd0);
                else check("latency", 32'(cyc - sb_q[0].acc), 32'd4);
            end
            if (out_valid && out_ready && sb_q.size() != 0) begin
                it = sb_q.pop_front();
                check("out_data", 32'(out_data), 32'(it.data));
                check("out_err", 32'(out_err), 32'(it.err));
                $display("word out data=%h err=%b (cycle %0d)", out_data, out_err, cyc);
            end
        end
        prev_valid = out_valid;
    end

    // Drive a word now (just after an edge) and hold it until accepted
    task automatic send_now(input logic [15:0] d, input logic [1:0] m, output int waited);
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        waited   = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 100) begin
                check("accept_timeout", 32'(waited), 32'd0);
                break;
            end
        end
        e     = model(d, m);
        e.acc = cyc + 1;
        sb_q.push_back(e);
        $display("word in  data=%h mode=%0d (cycle %0d)", d, m, cyc + 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mode  = ~m;
        in_data  = 16'($urandom);
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] m);
        int w;
        @(posedge clk);
        #1;
        send_now(d, m, w);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] snap_d;
        logic [3:0]  snap_e;
        int          w;
        int          n;
        int          seen;

        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        #22 rst_n = 1'b1;
        out_ready = 1'b1;

        send(16'h1293, 2'd1); wait_drain();
        send(16'h1293, 2'd2); wait_drain();
        send(16'h5678, 2'd3); wait_drain();
        send(16'h9081, 2'd0); wait_drain();
        send(16'h12A3, 2'd1); wait_drain();
        send(16'hFB0C, 2'd3); wait_drain();
        for (int i = 0; i < 8; i++) begin
            send(16'($urandom), 2'($urandom_range(0, 3)));
        end
        wait_drain();

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        send(16'h0417, 2'd1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        snap_d = out_data;
        snap_e = out_err;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_data_stable", 32'(out_data), 32'(snap_d));
            check("bp_err_stable", 32'(out_err), 32'(snap_e));
            check("bp_valid_held", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_now(16'h5678, 2'd3, w);
        check("zero_bubble_accept", 32'(w), 32'd0);
        wait_drain();

        // Reset during conversion: the word is dropped and nothing is emitted
        send(16'h4321, 2'd2);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_err", 32'(out_err), 32'd0);
        #13 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_output", 32'(seen), 32'd0);
        send(16'h1293, 2'd2);
        wait_drain();
        send(16'h12A3, 2'd0);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected 0", cyc);
        $fatal(1, "timeout");
    end

endmodule
